// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4x1 mux: one-hot grant plus registered
// select, with a bounded hold window under contention.
module mux4_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       valid
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

   state_t     state;
   logic [1:0] ptr;
   logic [3:0] hold_cnt;

   logic [2:0] pick;
   logic       found;
   logic [1:0] win;
   logic       others;
   logic       keep;
   logic       do_grant;

   // Returns {found, index}; the scan runs downward so the lowest offset from p wins.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   function automatic logic [3:0] hold_inc(input logic [3:0] cnt);
      return (cnt >= HOLD_LIM) ? HOLD_LIM : cnt + 4'd1;
   endfunction

   always_comb begin
      pick     = rr_pick(req, ptr);
      found    = pick[2];
      win      = pick[1:0];
      others   = |(req & ~gnt);
      keep     = (state == GRANT) && req[sel] && ((hold_cnt < HOLD_LIM) || !others);
      do_grant = found && !keep;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 4'b0000;
         sel      <= 2'd0;
         valid    <= 1'b0;
         ptr      <= 2'd0;
         hold_cnt <= 4'd0;
      end else if (keep) begin
         hold_cnt <= hold_inc(hold_cnt);
      end else if (do_grant) begin
         // The new owner drops to lowest priority for the next arbitration.
         state    <= GRANT;
         gnt      <= 4'b0001 << win;
         sel      <= win;
         valid    <= 1'b1;
         ptr      <= win + 2'd1;
         hold_cnt <= 4'd1;
      end else begin
         state <= IDLE;
         gnt   <= 4'b0000;
         valid <= 1'b0;
      end
   end

endmodule
